// File: rtl/rf_dump_reader_if.sv
// Beat stream from the register-file dump reader toward the display/debug link.
// Each accepted beat carries one register index and its captured value.
`timescale 1ns/1ps
interface rf_dump_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rf_dump_reader.sv
// Walks a (possibly wrapping) range of architectural registers through a dedicated
// read port and streams each captured {index, data} pair over a valid/ready link.
`timescale 1ns/1ps
module rf_dump_reader #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   first_reg,
  input  logic [ADDR_W-1:0]   last_reg,
  output logic [ADDR_W-1:0]   rR,
  input  logic [DATA_W-1:0]   rD,
  output logic                busy,
  output logic                done,
  rf_dump_reader_if.master    ob
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] cur_d;
  logic [ADDR_W-1:0] end_idx_q;
  logic              busy_q;
  logic              done_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;

  // Index advance wraps at NREGS so first > last walks through NREGS-1 to 0.
  assign cur_d = ADDR_W'((int'(cur_q) + 1) % NREGS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q     <= first_reg;
            end_idx_q <= last_reg;
            busy_q    <= 1'b1;
            state_q   <= READ;
          end
        end
        READ: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Snapshot: later writes to this register do not touch the offered beat.
            out_data_q  <= rD;
            out_addr_q  <= cur_q;
            out_last_q  <= (cur_q == end_idx_q);
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // Abort takes priority over a handshake on the same edge.
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (out_valid_q && ob.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q   <= cur_d;
              state_q <= READ;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rR           = cur_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ob.out_valid = out_valid_q;
  assign ob.out_addr  = out_addr_q;
  assign ob.out_data  = out_data_q;
  assign ob.out_last  = out_last_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a behavioural register file feeds the read
// port and each scenario task checks beats, timing and control pulses.
`timescale 1ns/1ps
module tb_rf_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rR;
  logic [31:0] rD;
  logic        busy;
  logic        done;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  logic [4:0]  b_addr [$];
  logic [31:0] b_data [$];
  logic        b_last [$];

  rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) ob ();

  rf_dump_reader #(.NREGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rR        (rR),
    .rD        (rD),
    .busy      (busy),
    .done      (done),
    .ob        (ob)
  );

  always #5 clk = ~clk;
  assign rD = rf[rR];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h1111;
  endtask

  // Runs one dump and records accepted beats. pat 0: ready always; pat 1: ready 1-of-3.
  // hook 1: pulse start with other bounds mid-dump; hook 2: overwrite x5 while it is offered.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int pat, input int hook,
                          output int stall_err, output int done_cnt, output bit tmo);
    logic        held_v;
    logic [4:0]  h_addr;
    logic [31:0] h_data;
    logic        h_last;
    bit          seen_done;
    b_addr.delete(); b_data.delete(); b_last.delete();
    stall_err = 0; done_cnt = 0; tmo = 1'b1; held_v = 1'b0; seen_done = 1'b0;
    h_addr = '0; h_data = '0; h_last = 1'b0;
    first_reg = f; last_reg = l; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin done_cnt++; seen_done = 1'b1; end
      if (seen_done && !done && !busy) begin tmo = 1'b0; break; end
      start = (hook == 1 && k == 3);
      if (hook == 1 && k == 3) begin first_reg = 5'd20; last_reg = 5'd21; end
      if (hook == 2 && ob.out_valid && ob.out_addr == 5'd5) rf[5] = 32'hDEAD;
      ob.out_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
      if (ob.out_valid) begin
        if (held_v && (ob.out_addr !== h_addr || ob.out_data !== h_data || ob.out_last !== h_last))
          stall_err++;
        if (ob.out_ready) begin
          b_addr.push_back(ob.out_addr); b_data.push_back(ob.out_data); b_last.push_back(ob.out_last);
        end
      end
      held_v = ob.out_valid && !ob.out_ready;
      h_addr = ob.out_addr; h_data = ob.out_data; h_last = ob.out_last;
      cyc();
    end
    start = 1'b0;
    ob.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    checks++;
    if ({busy, done, ob.out_valid, ob.out_last, ob.out_addr, ob.out_data, rR} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b v=%b last=%b addr=%0d data=%h rR=%0d, need all 0",
               busy, done, ob.out_valid, ob.out_last, ob.out_addr, ob.out_data, rR);
    end
  endtask

  task automatic test_single();
    rf[19] = 32'h0000_1234;
    ob.out_ready = 1'b1;
    first_reg = 5'd19; last_reg = 5'd19; start = 1'b1;
    cyc();  // E0
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ob.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_e0: busy=%b valid=%b, need busy=1 valid=0", busy, ob.out_valid);
    end
    cyc();  // E1
    checks++;
    if (ob.out_valid !== 1'b1 || ob.out_addr !== 5'd19 || ob.out_data !== 32'h1234 || ob.out_last !== 1'b1) begin
      errors++;
      $display("FAIL single_beat: v=%b addr=%0d data=%h last=%b, need v=1 addr=19 data=00001234 last=1",
               ob.out_valid, ob.out_addr, ob.out_data, ob.out_last);
    end
    cyc();  // E2 handshake
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || ob.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_done: done=%b busy=%b v=%b, need 1 1 0", done, busy, ob.out_valid);
    end
    cyc();  // E3
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_idle: done=%b busy=%b, need 0 0", done, busy);
    end
    ob.out_ready = 1'b0;
    rf[19] = 19 * 32'h1111;
  endtask

  task automatic test_full_backpressure();
    int se, dc; bit tmo; int bad;
    run_dump(5'd0, 5'd31, 1, 0, se, dc, tmo);
    checks++;
    if (tmo || b_addr.size() != 32 || dc != 1) begin
      errors++; $display("FAIL full_count: beats=%0d done=%0d timeout=%0b, need 32 1 0", b_addr.size(), dc, tmo);
    end
    bad = 0;
    for (int i = 0; i < b_addr.size() && i < 32; i++)
      if (b_addr[i] !== 5'(i) || b_data[i] !== i * 32'h1111 || b_last[i] !== (i == 31)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL full_payload: %0d bad beats, need 0", bad);
    end
    checks++;
    if (b_addr.size() > 0 && b_data[0] !== 32'h0) begin
      errors++; $display("FAIL full_x0: got %h need 00000000", b_data[0]);
    end
    checks++;
    if (se != 0) begin
      errors++; $display("FAIL full_stall_stable: %0d payload changes while stalled, need 0", se);
    end
  endtask

  task automatic test_wrap();
    int se, dc; bit tmo;
    logic [4:0] exp_a [4];
    exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
    run_dump(5'd30, 5'd1, 0, 0, se, dc, tmo);
    checks++;
    if (tmo || b_addr.size() != 4 || dc != 1) begin
      errors++; $display("FAIL wrap_count: beats=%0d done=%0d timeout=%0b, need 4 1 0", b_addr.size(), dc, tmo);
    end
    for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
      checks++;
      if (b_addr[i] !== exp_a[i] || b_data[i] !== exp_a[i] * 32'h1111 || b_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr=%0d data=%h last=%b, need addr=%0d data=%h last=%0d",
                 i, b_addr[i], b_data[i], b_last[i], exp_a[i], exp_a[i] * 32'h1111, (i == 3));
      end
    end
  endtask

  task automatic test_start_ignored();
    int se, dc; bit tmo; int bad;
    run_dump(5'd8, 5'd12, 0, 1, se, dc, tmo);
    checks++;
    if (tmo || b_addr.size() != 5 || dc != 1) begin
      errors++; $display("FAIL busy_start_count: beats=%0d done=%0d timeout=%0b, need 5 1 0", b_addr.size(), dc, tmo);
    end
    bad = 0;
    for (int i = 0; i < b_addr.size(); i++) if (b_addr[i] !== 5'(8 + i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL busy_start_range: %0d beats off range 8..12, need 0", bad);
    end
    cyc(); cyc();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL busy_start_requeue: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_snapshot();
    int se, dc; bit tmo;
    run_dump(5'd4, 5'd6, 1, 2, se, dc, tmo);
    checks++;
    if (tmo || b_data.size() != 3 || b_data[1] !== 32'h5555) begin
      errors++;
      $display("FAIL snapshot_old: beats=%0d x5=%h, need 3 00005555", b_data.size(),
               (b_data.size() > 1) ? b_data[1] : 32'hx);
    end
    run_dump(5'd5, 5'd5, 0, 0, se, dc, tmo);
    checks++;
    if (tmo || b_data.size() != 1 || b_data[0] !== 32'hDEAD) begin
      errors++;
      $display("FAIL snapshot_new: beats=%0d x5=%h, need 1 0000dead", b_data.size(),
               (b_data.size() > 0) ? b_data[0] : 32'hx);
    end
    rf[5] = 5 * 32'h1111;
  endtask

  task automatic test_abort(input bit use_reset);
    bit stray;
    ob.out_ready = 1'b1;
    first_reg = 5'd0; last_reg = 5'd31; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();  // through E5: third beat offered
    checks++;
    if (ob.out_valid !== 1'b1 || ob.out_addr !== 5'd2) begin
      errors++; $display("FAIL abort_setup%0d: v=%b addr=%0d, need 1 2", use_reset, ob.out_valid, ob.out_addr);
    end
    if (use_reset) rst_n = 1'b0; else abort = 1'b1;
    cyc();
    rst_n = 1'b1; abort = 1'b0;
    checks++;
    if (ob.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_stop%0d: v=%b busy=%b done=%b, need 0 0 0", use_reset, ob.out_valid, busy, done);
    end
    if (use_reset) begin
      checks++;
      if ({ob.out_last, ob.out_addr, ob.out_data, rR} !== '0) begin
        errors++;
        $display("FAIL reset_mid_vals: last=%b addr=%0d data=%h rR=%0d, need all 0",
                 ob.out_last, ob.out_addr, ob.out_data, rR);
      end
    end
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ob.out_valid || done || busy) stray = 1'b1;
      cyc();
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL abort_quiet%0d: activity after stop, need none", use_reset);
    end
    ob.out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    first_reg = '0; last_reg = '0; ob.out_ready = 1'b0;
    preload();
    test_reset();
    test_single();
    test_full_backpressure();
    test_wrap();
    test_start_ignored();
    test_snapshot();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
